// File: rtl/l1d_mshr_pkg.sv
// l1d_mshr_pkg
//   Shared widths and the allocation payload record handed from the L1D
//   tag-lookup stage to the MSHR entries.
//   need_rw encodes the final data-array access direction: 1 = write, 0 = read.
package l1d_mshr_pkg;

    localparam int L1D_MSHR_ID_WIDTH = 4;
    localparam int L1D_INDEX_WIDTH   = 6;
    localparam int L1D_TAG_WIDTH     = 20;
    localparam int L1D_OFFSET_WIDTH  = 4;
    localparam int L1D_WAY_NUM       = 4;
    localparam int L1D_DATA_WIDTH    = 64;
    localparam int L1D_BE_WIDTH      = L1D_DATA_WIDTH / 8;
    localparam int L1D_SB_PLD_WIDTH  = 8;

    typedef struct packed {
        logic [L1D_INDEX_WIDTH-1:0]   index;
        logic [L1D_TAG_WIDTH-1:0]     new_tag;
        logic [L1D_TAG_WIDTH-1:0]     evict_tag;
        logic [L1D_OFFSET_WIDTH-1:0]  offset;
        logic                         need_rw;
        logic [L1D_DATA_WIDTH-1:0]    wr_data;
        logic [L1D_BE_WIDTH-1:0]      wr_byte_en;
        logic [L1D_SB_PLD_WIDTH-1:0]  wr_sb_pld;
        logic [L1D_MSHR_ID_WIDTH-1:0] mshr_hzd_index_way_line;
        logic [L1D_MSHR_ID_WIDTH-1:0] mshr_hzd_evict_tag_line;
        logic                         need_evict;
        logic                         need_linefill;
        logic [L1D_WAY_NUM-1:0]       way;
        logic [L1D_MSHR_ID_WIDTH-1:0] mshr_id;
    } pack_l1d_mshr_state;

endpackage

// File: rtl/l1d_mshr_entry.sv
// l1d_mshr_entry
//   One MSHR entry. Latches an allocation, waits for the entries it depends
//   on to release, then runs evict -> linefill -> final data-array access and
//   broadcasts its own release for one cycle.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   alloc_vld/alloc_pld           allocation; taken only when idle and mshr_id==ENTRY_ID
//   alloc_hzd_idx_vld/_evt_vld    the payload's hazard ids are live dependencies
//   release_vld/release_id        release broadcast from any entry
//   busy                          entry occupied
//   evict_req_*/evict_done        write-back request handshake and completion
//   linefill_req_*/linefill_done  refill request handshake and completion
//   rw_req_vld/rw_req_rdy         final data-array access handshake
//   req_index/req_way/req_tag     target line; tag is evict_tag while evicting
//   rw_*                          latched access info
//   rel_vld/rel_id                one-cycle release pulse, id = ENTRY_ID
//   err_timeout                   sticky watchdog flag
//
// Optional feature: define L1D_MSHR_TIMEOUT_EN to build a watchdog that sets
// err_timeout after TIMEOUT_CYCLES busy cycles without a state change.
// Without it err_timeout is tied low.
module l1d_mshr_entry
    import l1d_mshr_pkg::*;
#(
    parameter logic [L1D_MSHR_ID_WIDTH-1:0] ENTRY_ID       = '0,
    parameter int                           TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         alloc_vld,
    input  pack_l1d_mshr_state           alloc_pld,
    input  logic                         alloc_hzd_idx_vld,
    input  logic                         alloc_hzd_evt_vld,
    input  logic                         release_vld,
    input  logic [L1D_MSHR_ID_WIDTH-1:0] release_id,
    output logic                         busy,
    output logic                         evict_req_vld,
    input  logic                         evict_req_rdy,
    input  logic                         evict_done,
    output logic                         linefill_req_vld,
    input  logic                         linefill_req_rdy,
    input  logic                         linefill_done,
    output logic                         rw_req_vld,
    input  logic                         rw_req_rdy,
    output logic [L1D_INDEX_WIDTH-1:0]   req_index,
    output logic [L1D_WAY_NUM-1:0]       req_way,
    output logic [L1D_TAG_WIDTH-1:0]     req_tag,
    output logic                         rw_is_read,
    output logic [L1D_OFFSET_WIDTH-1:0]  rw_offset,
    output logic [L1D_DATA_WIDTH-1:0]    rw_data,
    output logic [L1D_BE_WIDTH-1:0]      rw_byte_en,
    output logic [L1D_SB_PLD_WIDTH-1:0]  rw_sb_pld,
    output logic                         rel_vld,
    output logic [L1D_MSHR_ID_WIDTH-1:0] rel_id,
    output logic                         err_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_HZD,
        S_EVICT_REQ,
        S_EVICT_WAIT,
        S_LINEFILL_REQ,
        S_LINEFILL_WAIT,
        S_RW_REQ,
        S_RELEASE
    } state_t;

    state_t state, state_nxt;

    logic                         hzd_idx_pend, hzd_idx_pend_nxt;
    logic                         hzd_evt_pend, hzd_evt_pend_nxt;
    logic [L1D_MSHR_ID_WIDTH-1:0] hzd_idx_id_q, hzd_evt_id_q;
    logic                         need_evict_q, need_linefill_q;
    logic [L1D_TAG_WIDTH-1:0]     new_tag_q, evict_tag_q;

    logic alloc_fire;
    logic alloc_idx_set, alloc_evt_set;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cycles
        $error("l1d_mshr_entry: TIMEOUT_CYCLES must be at least 1");
    end

    function automatic state_t dispatch(input logic need_evict, input logic need_linefill);
        if (need_evict)    return S_EVICT_REQ;
        if (need_linefill) return S_LINEFILL_REQ;
        return S_RW_REQ;
    endfunction

    assign alloc_fire = alloc_vld && (alloc_pld.mshr_id == ENTRY_ID) && (state == S_IDLE);

    // A hazard on ourselves is no dependency, and a release arriving in the
    // allocation cycle has already happened, so neither may arm a flag.
    assign alloc_idx_set = alloc_hzd_idx_vld
                        && (alloc_pld.mshr_hzd_index_way_line != ENTRY_ID)
                        && !(release_vld && (release_id == alloc_pld.mshr_hzd_index_way_line));
    assign alloc_evt_set = alloc_hzd_evt_vld
                        && (alloc_pld.mshr_hzd_evict_tag_line != ENTRY_ID)
                        && !(release_vld && (release_id == alloc_pld.mshr_hzd_evict_tag_line));

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_nxt        = state;
        hzd_idx_pend_nxt = hzd_idx_pend;
        hzd_evt_pend_nxt = hzd_evt_pend;
        case (state)
            S_IDLE: begin
                if (alloc_fire) begin
                    hzd_idx_pend_nxt = alloc_idx_set;
                    hzd_evt_pend_nxt = alloc_evt_set;
                    if (alloc_idx_set || alloc_evt_set) state_nxt = S_WAIT_HZD;
                    else state_nxt = dispatch(alloc_pld.need_evict, alloc_pld.need_linefill);
                end
            end
            S_WAIT_HZD: begin
                if (release_vld && (release_id == hzd_idx_id_q)) hzd_idx_pend_nxt = 1'b0;
                if (release_vld && (release_id == hzd_evt_id_q)) hzd_evt_pend_nxt = 1'b0;
                if (!hzd_idx_pend_nxt && !hzd_evt_pend_nxt)
                    state_nxt = dispatch(need_evict_q, need_linefill_q);
            end
            S_EVICT_REQ:     if (evict_req_rdy)    state_nxt = S_EVICT_WAIT;
            S_EVICT_WAIT:    if (evict_done)       state_nxt = S_LINEFILL_REQ;
            S_LINEFILL_REQ:  if (linefill_req_rdy) state_nxt = S_LINEFILL_WAIT;
            S_LINEFILL_WAIT: if (linefill_done)    state_nxt = S_RW_REQ;
            S_RW_REQ:        if (rw_req_rdy)       state_nxt = S_RELEASE;
            S_RELEASE:                             state_nxt = S_IDLE;
            default:                               state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they are clean
    // Moore flops rather than decodes of the state vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= S_IDLE;
            busy             <= 1'b0;
            evict_req_vld    <= 1'b0;
            linefill_req_vld <= 1'b0;
            rw_req_vld       <= 1'b0;
            rel_vld          <= 1'b0;
            hzd_idx_pend     <= 1'b0;
            hzd_evt_pend     <= 1'b0;
            // NOTE: the payload is a handful of flops that drive outputs
            // directly, so it takes reset; a RAM-style store would not.
            hzd_idx_id_q     <= '0;
            hzd_evt_id_q     <= '0;
            need_evict_q     <= 1'b0;
            need_linefill_q  <= 1'b0;
            new_tag_q        <= '0;
            evict_tag_q      <= '0;
            req_index        <= '0;
            req_way          <= '0;
            rw_is_read       <= 1'b0;
            rw_offset        <= '0;
            rw_data          <= '0;
            rw_byte_en       <= '0;
            rw_sb_pld        <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples the
            // pre-edge values regardless of statement order.
            state            <= state_nxt;
            busy             <= (state_nxt != S_IDLE);
            evict_req_vld    <= (state_nxt == S_EVICT_REQ);
            linefill_req_vld <= (state_nxt == S_LINEFILL_REQ);
            rw_req_vld       <= (state_nxt == S_RW_REQ);
            rel_vld          <= (state_nxt == S_RELEASE);
            hzd_idx_pend     <= hzd_idx_pend_nxt;
            hzd_evt_pend     <= hzd_evt_pend_nxt;
            if (alloc_fire) begin
                hzd_idx_id_q    <= alloc_pld.mshr_hzd_index_way_line;
                hzd_evt_id_q    <= alloc_pld.mshr_hzd_evict_tag_line;
                need_evict_q    <= alloc_pld.need_evict;
                need_linefill_q <= alloc_pld.need_linefill;
                new_tag_q       <= alloc_pld.new_tag;
                evict_tag_q     <= alloc_pld.evict_tag;
                req_index       <= alloc_pld.index;
                req_way         <= alloc_pld.way;
                rw_is_read      <= !alloc_pld.need_rw;
                rw_offset       <= alloc_pld.offset;
                rw_data         <= alloc_pld.wr_data;
                rw_byte_en      <= alloc_pld.wr_byte_en;
                rw_sb_pld       <= alloc_pld.wr_sb_pld;
            end
        end
    end

    assign req_tag = (state == S_EVICT_REQ) ? evict_tag_q : new_tag_q;
    assign rel_id  = ENTRY_ID;

`ifdef L1D_MSHR_TIMEOUT_EN
    localparam int                TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0]   TO_MAX  = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt;

    // Counts busy cycles spent in the current state; saturates at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt      <= '0;
            err_timeout <= 1'b0;
        end else if (state_nxt != state) begin
            to_cnt <= '0;
        end else if (busy && (to_cnt != TO_MAX)) begin
            to_cnt <= to_cnt + 1'b1;
            if (to_cnt == TO_LAST) err_timeout <= 1'b1;
        end
    end
`else
    assign err_timeout = 1'b0;
`endif

    a_no_alloc_when_busy: assert property (
        @(posedge clk) disable iff (rst)
        !(alloc_vld && (alloc_pld.mshr_id == ENTRY_ID) && busy)
    ) else $warning("l1d_mshr_entry %0d: allocation while busy ignored", ENTRY_ID);

endmodule

// File: doc/l1d_mshr_entry.md
Name: l1d_mshr_entry

Overview:
Single MSHR entry: the consumer of the pack_l1d_mshr_state allocation payload produced by the tag-lookup behaviour map. It latches one miss/hit request and waits for hazards on other entries to release. It then sequences evict, linefill and the final data-array read/write. On completion it broadcasts its own release so dependent entries can proceed. N copies are instantiated in the MSHR array, one per ENTRY_ID.

Parameters:
ENTRY_ID, 0, this entry's MSHR id; compared against alloc_pld.mshr_id and driven on rel_id
L1D_MSHR_ID_WIDTH, package value, width of all mshr id fields
TIMEOUT_CYCLES, 1024, watchdog limit; used only with L1D_MSHR_TIMEOUT_EN

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
alloc_vld  in  1  allocate this entry; accepted only when alloc_pld.mshr_id==ENTRY_ID and busy==0
alloc_pld  in  pack_l1d_mshr_state  allocation payload (index, new_tag, evict_tag, offset, need_rw, wr data/byte_en, wr_sb_pld, hazard ids, need_evict, need_linefill, way, mshr_id)
alloc_hzd_idx_vld  in  1  mshr_hzd_index_way_line is a live dependency
alloc_hzd_evt_vld  in  1  mshr_hzd_evict_tag_line is a live dependency
release_vld  in  1  broadcast: some entry released this cycle
release_id  in  L1D_MSHR_ID_WIDTH  id of releasing entry
busy  out  1  entry occupied (state != IDLE)
evict_req_vld  out  1  evict request to the write-back path
evict_req_rdy  in  1  evict request accepted
evict_done  in  1  evict data read out; line may be overwritten
linefill_req_vld  out  1  linefill request to downstream
linefill_req_rdy  in  1  linefill accepted
linefill_done  in  1  fill data written into data array
rw_req_vld  out  1  final data-array access request
rw_req_rdy  in  1  access accepted
req_index / req_way / req_tag  out  pkg widths  index, one-hot way; tag = evict_tag in EVICT_REQ, otherwise new_tag
rw_is_read / rw_offset / rw_data / rw_byte_en / rw_sb_pld  out  pkg widths  latched write/read info
rel_vld  out  1  one-cycle release pulse
rel_id  out  L1D_MSHR_ID_WIDTH  constant ENTRY_ID
err_timeout  out  1  sticky watchdog flag (feature only; 0 otherwise)

Behaviour:
- Reset (async, immediate): state=IDLE, busy=0, every *_vld=0, rel_vld=0, hazard flags=0, payload regs=0, err_timeout=0.
- States: IDLE, WAIT_HZD, EVICT_REQ, EVICT_WAIT, LINEFILL_REQ, LINEFILL_WAIT, RW_REQ, RELEASE.
- Moore outputs only: evict_req_vld=(EVICT_REQ); linefill_req_vld=(LINEFILL_REQ); rw_req_vld=(RW_REQ); rel_vld=(RELEASE). Payload outputs are driven from the latched registers.
- IDLE plus accepted alloc: latch payload. Set hzd_idx_pend=alloc_hzd_idx_vld, unless release_vld && release_id==mshr_hzd_index_way_line in the same cycle, in which case it is not set. hzd_evt_pend is set likewise from alloc_hzd_evt_vld.
- Next state after alloc: WAIT_HZD if any pend flag is set. Otherwise dispatch: need_evict -> EVICT_REQ; else need_linefill -> LINEFILL_REQ; else RW_REQ.
- WAIT_HZD: each pend flag clears on release_vld && release_id==its stored id. Dispatch (same rule as above) in the cycle after both flags are 0.
- A hazard id equal to ENTRY_ID is treated as no dependency; the flag is never set.
- EVICT_REQ: hold vld and payload stable until rdy. vld&&rdy -> EVICT_WAIT.
- EVICT_WAIT: on evict_done -> LINEFILL_REQ (need_linefill is always 1 when need_evict=1).
- LINEFILL_REQ: vld&&rdy -> LINEFILL_WAIT.
- LINEFILL_WAIT: on linefill_done -> RW_REQ.
- RW_REQ: vld&&rdy -> RELEASE.
- RELEASE: rel_vld=1 for exactly one cycle, then IDLE. busy is 1 during RELEASE; a new alloc is accepted from the following cycle.
- done/rdy inputs asserted in any other state are ignored.
- alloc_vld for this id while busy: ignored, state unchanged; an SVA assertion flags it.
- Minimum latency (hit, no hazard, rdy tied 1): alloc at cycle 0; rw_req_vld at cycle 1; rel_vld at cycle 2; IDLE at cycle 3.

Optional Feature:
L1D_MSHR_TIMEOUT_EN:
- Defined: a counter clears on every state change and increments while busy. Reaching TIMEOUT_CYCLES sets err_timeout, which is sticky until rst. The counter saturates; state flow is unaffected.
- Undefined: no counter is instantiated and err_timeout is tied 0.

Test Plan:
1. Hit, no hazard, ENTRY_ID=3, alloc mshr_id=3, need_evict=0, need_linefill=0, rdy=1 -> rw_req_vld at cycle 1, rel_vld with rel_id=3 at cycle 2, busy=0 at cycle 3.
2. Dirty miss (need_evict=1, need_linefill=1), evict_done 5 cycles after rdy, linefill_done 7 cycles after rdy -> strict order EVICT_REQ -> EVICT_WAIT -> LINEFILL_REQ -> LINEFILL_WAIT -> RW_REQ. req_tag=evict_tag during evict, new_tag afterwards.
3. Hazards idx=5, evt=6, both valid; release 6 at cycle 4, release 5 at cycle 9 -> stays WAIT_HZD through cycle 9, linefill_req_vld at cycle 10.
4. Alloc with hazard idx=2 while release_vld=1, release_id=2 in the same cycle -> WAIT_HZD skipped; dispatch at cycle 1.
5. rw_req_rdy held 0 for 4 cycles -> rw_req_vld and all rw_* payloads stable; a second alloc to this id during the stall is ignored and the assertion fires.
6. rst asserted mid-LINEFILL_WAIT -> all vld outputs 0 and busy 0 immediately (asynchronously); a later linefill_done is ignored; with L1D_MSHR_TIMEOUT_EN and TIMEOUT_CYCLES=16, a stalled evict_done sets err_timeout at the 16th busy cycle.
